// File: rtl/dpram_capture_ctrl_pkg.sv
// Shared types and default sizes for the sample-capture controller.
// The buffer depth follows from the address width.
package dpram_capture_ctrl_pkg;

  localparam int ADDR_WIDTH_DEF = 13;
  localparam int DATA_WIDTH_DEF = 11;
  localparam int DEPTH          = 2 ** ADDR_WIDTH_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE_FILL,
    ST_WAIT_TRIG,
    ST_POST_FILL,
    ST_READOUT
  } cap_state_e;

endpackage

// File: rtl/dpram_capture_ctrl_rd_port.sv
// Readout side: walks the RAM from the oldest sample and streams it out.
// Handshake: a word transfers on every cycle where rd_valid && rd_ready; while
// rd_valid && !rd_ready the read address is held, so rd_data stays stable.
module capture_rd_port
  import dpram_capture_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  active,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  abort,
  input  logic                  rd_ready,
  input  logic [DATA_WIDTH-1:0] ram_b_rd_data,
  output logic [ADDR_WIDTH-1:0] ram_b_addr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  done,
  output logic                  last_accept
);

  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic                  fire;

  assign fire        = rd_valid && rd_ready;
  assign rd_last     = rd_valid && (rd_cnt == '1);
  assign last_accept = fire && rd_last;
  assign rd_data     = ram_b_rd_data;

  // Look one word ahead on a transfer so the RAM latency never costs a bubble.
  assign ram_b_addr = !active ? '0 : (fire ? rd_ptr + 1'b1 : rd_ptr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      rd_cnt   <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (start) begin
        rd_ptr <= start_addr;
        rd_cnt <= '0;
      end else if (fire) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_cnt <= rd_cnt + 1'b1;
      end
      rd_valid <= active && !abort && !last_accept;
      done     <= last_accept && !abort;
    end
  end

endmodule

// File: rtl/dpram_capture_ctrl.sv
// Pre/post-trigger capture into a dual-port RAM, then full-buffer readout.
// The FSM and write port live here; the read side is capture_rd_port.
module dpram_capture_ctrl
  import dpram_capture_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] pre_len,
  input  logic                  trig,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic [ADDR_WIDTH-1:0] ram_a_addr,
  output logic [DATA_WIDTH-1:0] ram_a_wr_data,
  output logic                  ram_a_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_b_addr,
  input  logic [DATA_WIDTH-1:0] ram_b_rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_CNT  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  cap_state_e            state, state_next;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] pre_q;
  logic [ADDR_WIDTH-1:0] trig_addr;
  logic [ADDR_WIDTH:0]   cnt;
  logic [ADDR_WIDTH:0]   cnt_inc;
  logic [ADDR_WIDTH:0]   post_target;
  logic                  capturing;
  logic                  hit;
  logic                  enter_readout;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic                  last_accept;

  assign capturing   = (state == ST_PRE_FILL) || (state == ST_WAIT_TRIG) ||
                       (state == ST_POST_FILL);
  assign hit         = (state == ST_WAIT_TRIG) && sample_valid && trig;
  assign cnt_inc     = cnt + 1'b1;
  assign post_target = FULL_CNT - {1'b0, pre_q};

  assign ram_a_wr_en   = capturing && sample_valid && !abort;
  assign ram_a_addr    = wr_ptr;
  assign ram_a_wr_data = sample_data;
  assign busy          = (state != ST_IDLE);

  always_comb begin
    state_next    = state;
    enter_readout = 1'b0;
    start_addr    = trig_addr - pre_q;
    case (state)
      ST_IDLE:
        if (arm) state_next = (pre_len == '0) ? ST_WAIT_TRIG : ST_PRE_FILL;
      ST_PRE_FILL:
        if (sample_valid && cnt_inc == {1'b0, pre_q}) state_next = ST_WAIT_TRIG;
      ST_WAIT_TRIG:
        if (hit) begin
          // With pre_q = DEPTH-1 the trigger sample alone completes the buffer.
          if (post_target == ONE_CNT) begin
            state_next    = ST_READOUT;
            enter_readout = 1'b1;
            start_addr    = wr_ptr - pre_q;
          end else begin
            state_next = ST_POST_FILL;
          end
        end
      ST_POST_FILL:
        if (sample_valid && cnt_inc == post_target) begin
          state_next    = ST_READOUT;
          enter_readout = 1'b1;
        end
      ST_READOUT:
        if (last_accept) state_next = ST_IDLE;
      default:
        state_next = ST_IDLE;
    endcase
    if (abort) begin
      state_next    = ST_IDLE;
      enter_readout = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      pre_q     <= '0;
      trig_addr <= '0;
      cnt       <= '0;
    end else if (!abort) begin
      if (state == ST_IDLE && arm) begin
        pre_q  <= pre_len;
        wr_ptr <= '0;
        cnt    <= '0;
      end
      if (capturing && sample_valid) wr_ptr <= wr_ptr + 1'b1;
      if ((state == ST_PRE_FILL || state == ST_POST_FILL) && sample_valid)
        cnt <= cnt_inc;
      if (hit) begin
        trig_addr <= wr_ptr;
        cnt       <= ONE_CNT;
      end
    end
  end

  capture_rd_port #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rd_port (
    .clk          (clk),
    .rst          (rst),
    .active       (state == ST_READOUT),
    .start        (enter_readout),
    .start_addr   (start_addr),
    .abort        (abort),
    .rd_ready     (rd_ready),
    .ram_b_rd_data(ram_b_rd_data),
    .ram_b_addr   (ram_b_addr),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .done         (done),
    .last_accept  (last_accept)
  );

endmodule

// File: tb/tb_dpram_capture_ctrl.sv
// Bench for dpram_capture_ctrl paired with an 8192x11 dual-port RAM model
// (port A write, port B read, one-cycle read latency, no output register).
module tb_dpram_capture_ctrl;
  import dpram_capture_ctrl_pkg::*;

  localparam int AW = 13;
  localparam int DW = 11;
  localparam int NW = 8192;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] pre_len = '0;
  logic          trig = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic [AW-1:0] ram_a_addr;
  logic [DW-1:0] ram_a_wr_data;
  logic          ram_a_wr_en;
  logic [AW-1:0] ram_b_addr;
  logic [DW-1:0] ram_b_rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          busy;
  logic          done;

  dpram_capture_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .abort        (abort),
    .pre_len      (pre_len),
    .trig         (trig),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .ram_a_addr   (ram_a_addr),
    .ram_a_wr_data(ram_a_wr_data),
    .ram_a_wr_en  (ram_a_wr_en),
    .ram_b_addr   (ram_b_addr),
    .ram_b_rd_data(ram_b_rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .busy         (busy),
    .done         (done)
  );

  // DPRAM_8192x11 behaviour
  logic [DW-1:0] ram [NW];
  always @(posedge clk) begin
    if (ram_a_wr_en) ram[ram_a_addr] <= ram_a_wr_data;
    ram_b_rd_data <= ram[ram_b_addr];
  end

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int words_seen = 0, data_err = 0, last_err = 0, stall_err = 0, done_cnt = 0;
  int run_base = 0;
  int w0, e0, l0, s0, d0;
  int ready_pct = 100;
  int ready_limit = 1 << 30;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] exp_w;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // readout monitor
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          data_err++;
        end else begin
          exp_w = exp_q.pop_front();
          if (rd_data !== exp_w) begin
            data_err++;
            if (data_err <= 3)
              $display("  word %0d: got %0d expected %0d", words_seen - run_base, rd_data, exp_w);
          end
        end
        if (rd_last !== ((words_seen - run_base) == NW - 1)) last_err++;
        words_seen++;
      end
      if (prev_stall && rd_valid && rd_data !== prev_data) stall_err++;
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      if (done) done_cnt++;
    end
  end

  // downstream ready driver
  always @(posedge clk) begin
    #1;
    rd_ready = ((words_seen - run_base) < ready_limit) && ($urandom_range(99) < ready_pct);
  end

  // driver tasks
  task automatic arm_pulse(input int pre);
    @(posedge clk); #1;
    pre_len = pre[AW-1:0];
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic feed(input int first, input int n, input int t_real, input int t_f1,
                      input int t_f2, input int pct);
    int k = first;
    while (k < first + n) begin
      @(posedge clk); #1;
      if ($urandom_range(99) < pct) begin
        sample_valid = 1'b1;
        sample_data  = k[DW-1:0];
        trig = (k == t_real) || (k == t_f1) || (k == t_f2);
        k++;
      end else begin
        sample_valid = 1'b0;
        sample_data  = DW'($urandom_range(2047));
        trig = 1'($urandom_range(1));
      end
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
    trig = 1'b0;
  endtask

  task automatic begin_run(input int oldest);
    w0 = words_seen; e0 = data_err; l0 = last_err; s0 = stall_err; d0 = done_cnt;
    run_base = words_seen;
    exp_q.delete();
    for (int j = 0; j < NW; j++) exp_q.push_back(DW'((oldest + j) & 'h7ff));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int t = 0;
    while (done_cnt == d0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done_in_time"}, 32'(t < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_words(input string tag, input int n, input int budget);
    int t = 0;
    while ((words_seen - run_base) < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_words_in_time"}, 32'(t < budget), 1);
  endtask

  task automatic end_run(input string tag, input int n_words, input int n_done);
    check({tag, "_words"}, words_seen - w0, n_words);
    check({tag, "_data_err"}, data_err - e0, 0);
    check({tag, "_last_err"}, last_err - l0, 0);
    check({tag, "_stall_err"}, stall_err - s0, 0);
    check({tag, "_done_pulses"}, done_cnt - d0, n_done);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", ram_a_wr_en, 0);
    check("rst_a_addr", ram_a_addr, 0);
    check("rst_b_addr", ram_b_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // arm together with abort in IDLE: abort wins
    @(posedge clk); #1;
    arm = 1'b1; abort = 1'b1; pre_len = 13'd5;
    @(posedge clk); #1;
    arm = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("arm_abort_busy", busy, 0);

    // pre 100, trig on sample 500; a second arm in PRE_FILL must be ignored
    ready_pct = 100;
    begin_run(400);
    arm_pulse(100);
    arm_pulse(7);
    feed(0, 8592, 500, -1, -1, 100);
    wait_done("a", 12000);
    end_run("a", NW, 1);

    // pre 50, trig pulses at 10 and 40 ignored, 60 captured, then abort in POST_FILL
    begin_run(0);
    arm_pulse(50);
    feed(0, 46, 60, 10, 40, 100);
    @(negedge clk);
    check("b_state_pre", dut.state, ST_PRE_FILL);
    feed(46, 10, 60, 10, 40, 100);
    @(negedge clk);
    check("b_state_wait", dut.state, ST_WAIT_TRIG);
    feed(56, 15, 60, 10, 40, 100);
    @(negedge clk);
    check("b_state_post", dut.state, ST_POST_FILL);
    check("b_trig_addr", dut.trig_addr, 60);
    @(posedge clk); #1;
    abort = 1'b1; sample_valid = 1'b1; sample_data = 11'd5;
    @(negedge clk);
    check("b_abort_no_write", ram_a_wr_en, 0);
    @(posedge clk); #1;
    abort = 1'b0; sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("b_state_idle", dut.state, ST_IDLE);
    end_run("b", 0, 0);

    // pre 0, trig on first valid sample, 30% sample_valid and 50% rd_ready
    ready_pct = 50;
    begin_run(0);
    arm_pulse(0);
    feed(0, NW, 0, -1, -1, 30);
    wait_done("c", 40000);
    end_run("c", NW, 1);

    // pre 8191, trig on sample 20000; hold the last word, then reset mid-readout
    ready_pct = 100;
    ready_limit = NW - 1;
    begin_run(11809);
    arm_pulse(8191);
    feed(0, 20001, 20000, -1, -1, 100);
    wait_words("d", NW - 1, 12000);
    repeat (2) @(negedge clk);
    check("d_hold_valid", rd_valid, 1);
    check("d_hold_last", rd_last, 1);
    check("d_hold_trig_word", rd_data, 20000 % 2048);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("d_rst_busy", busy, 0);
    check("d_rst_rd_valid", rd_valid, 0);
    check("d_rst_b_addr", ram_b_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ready_limit = 1 << 30;
    repeat (2) @(negedge clk);
    check("d_words", words_seen - w0, NW - 1);
    check("d_data_err", data_err - e0, 0);
    check("d_last_err", last_err - l0, 0);
    check("d_done_pulses", done_cnt - d0, 0);

    // first arm after reset starts writing from address 0
    arm_pulse(4);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      sample_valid = 1'b1;
      sample_data  = DW'(100 + k);
      @(negedge clk);
      check("g_wr_en", ram_a_wr_en, 1);
      check("g_wr_addr", ram_a_addr, k);
      check("g_wr_data", ram_a_wr_data, 100 + k);
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("g_abort_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
